// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM modulator/demodulator pair.
package pdm_pkg;

    localparam logic [15:0] MID = 16'h8000;

    typedef logic signed [15:0] pdm_duty_t;

    // Clamp a 17-bit unsigned value to the 16-bit unsigned range.
    function automatic logic [15:0] sat16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

endpackage

// File: rtl/pdm_window_integ.sv
// Front end of the PDM demodulator: synchronizer, sample strobe and
// integrate-and-dump window producing one offset-removed value per window.
module pdm_window_integ
    import pdm_pkg::*;
#(
    parameter int LOG2_WIN = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      pdm_in,
    output pdm_duty_t win_val,
    output logic      win_rdy
);

    localparam logic [LOG2_WIN-1:0] CNT_LAST = '1;

    logic                sync1;
    logic                sync2;
    logic                smp;
    logic [LOG2_WIN-1:0] cnt;
    logic [LOG2_WIN:0]   ones;
    logic [LOG2_WIN:0]   raw;
    logic [16:0]         scaled;

    // raw reaches W when every sample is set, so the 17-bit scaled value
    // can overflow 16 bits and must be clamped before the offset is removed.
    always_comb begin
        raw    = ones + {{LOG2_WIN{1'b0}}, sync2};
        scaled = 17'(raw) << (16 - LOG2_WIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            smp     <= 1'b0;
            cnt     <= '0;
            ones    <= '0;
            win_val <= '0;
            win_rdy <= 1'b0;
        end else begin
            sync1 <= pdm_in;
            sync2 <= sync1;
            smp   <= ~smp;
            if (!en) begin
                cnt     <= '0;
                ones    <= '0;
                win_rdy <= 1'b0;
            end else if (smp) begin
                if (cnt == CNT_LAST) begin
                    win_val <= pdm_duty_t'(sat16(scaled) - MID);
                    cnt     <= '0;
                    ones    <= '0;
                    win_rdy <= 1'b1;
                end else begin
                    cnt     <= cnt + 1'b1;
                    ones    <= raw;
                    win_rdy <= 1'b0;
                end
            end else begin
                win_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pdm_demod.sv
// PDM-to-PCM demodulator: window integrator followed by a four-window
// moving average of the recovered duty values.
module pdm_demod
    import pdm_pkg::*;
#(
    parameter int LOG2_WIN = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      pdm_in,
    output pdm_duty_t duty_out,
    output logic      vld
);

    pdm_duty_t          win_val;
    logic               win_rdy;
    pdm_duty_t          hist0;
    pdm_duty_t          hist1;
    pdm_duty_t          hist2;
    logic signed [17:0] sum;

    pdm_window_integ #(
        .LOG2_WIN (LOG2_WIN)
    ) u_integ (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .pdm_in  (pdm_in),
        .win_val (win_val),
        .win_rdy (win_rdy)
    );

    always_comb begin
        sum = {{2{win_val[15]}}, win_val} + {{2{hist0[15]}}, hist0}
            + {{2{hist1[15]}}, hist1}     + {{2{hist2[15]}}, hist2};
    end

    // History and output survive en going low; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist0    <= '0;
            hist1    <= '0;
            hist2    <= '0;
            duty_out <= '0;
            vld      <= 1'b0;
        end else if (win_rdy) begin
            duty_out <= pdm_duty_t'(sum >>> 2);
            hist2    <= hist1;
            hist1    <= hist0;
            hist0    <= win_val;
            vld      <= 1'b1;
        end else begin
            vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_demod.sv
// Bench for pdm_demod: LOG2_WIN=4 vector table plus a LOG2_WIN=8 instance
// checked every cycle against a sample-list reference model.
module tb_pdm_demod;
    import pdm_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      en = 1'b0;
    logic      pdm_in = 1'b0;
    pdm_duty_t duty4, duty8;
    logic      vld4, vld8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pdm_demod #(.LOG2_WIN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .pdm_in(pdm_in),
        .duty_out(duty4), .vld(vld4));

    pdm_demod #(.LOG2_WIN(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .pdm_in(pdm_in),
        .duty_out(duty8), .vld(vld8));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model for W=256: the bit used at edge k is pdm_in seen at
    // edge k-2; odd-numbered edges since reset are the sample edges.
    int        m_edge;
    bit        m_pin[$];
    bit        m_win[$];
    int        m_hist[$];
    bit        m_pend;
    int        m_pend_val;
    logic [15:0] m_duty;
    logic      m_vld;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edge = 0;
            m_pin.delete();
            m_win.delete();
            m_hist = '{0, 0, 0};
            m_pend = 0;
            m_pend_val = 0;
            m_duty = 16'h0000;
            m_vld = 1'b0;
        end else begin
            int total, ones, v;
            bit b;
            if (m_pend) begin
                total = m_pend_val + m_hist[0] + m_hist[1] + m_hist[2];
                m_duty = 16'((total >= 0) ? total / 4 : -((3 - total) / 4));
                m_hist.push_front(m_pend_val);
                void'(m_hist.pop_back());
                m_vld = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
            m_pin.push_back(pdm_in);
            if (m_pin.size() > 3) void'(m_pin.pop_front());
            b = (m_pin.size() == 3) ? m_pin[0] : 1'b0;
            m_pend = 0;
            if (!en) begin
                m_win.delete();
            end else if (m_edge % 2 == 1) begin
                m_win.push_back(b);
                if (m_win.size() == 256) begin
                    ones = 0;
                    foreach (m_win[i]) ones += int'(m_win[i]);
                    v = ones * 256;
                    if (v > 65535) v = 65535;
                    m_pend_val = v - 32768;
                    m_pend = 1;
                    m_win.delete();
                end
            end
            m_edge++;
        end
    end

    always @(negedge clk)
        check("stream8", {15'b0, vld8, duty8}, {15'b0, m_vld, m_duty});

    // Stimulus source: 0 hold level, 1 random, 2 toggle per sample, 3 sigma-delta modulator
    int          mode = 0;
    logic        level = 1'b0;
    int          tgl = 0;
    bit          sd_ph = 0;
    logic [15:0] sd_acc = 16'h0000;
    logic [15:0] sd_duty = 16'h0000;
    logic [16:0] sd_sum;

    always @(negedge clk) begin
        case (mode)
            0: pdm_in = level;
            1: pdm_in = 1'($urandom_range(1, 0));
            2: begin
                if (tgl % 2 == 0) pdm_in = ~pdm_in;
                tgl++;
            end
            default: begin
                sd_ph = ~sd_ph;
                if (sd_ph) begin
                    sd_sum = {1'b0, sd_acc} + {1'b0, sd_duty + MID};
                    sd_acc = sd_sum[15:0];
                    pdm_in = sd_sum[16];
                end
            end
        endcase
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_vld(input bit sel8, input int limit, output int n);
        logic v;
        n = 0;
        v = 1'b0;
        while (!v && n < limit) begin
            @(negedge clk);
            n++;
            v = sel8 ? vld8 : vld4;
        end
        if (!v) begin
            checks++;
            errors++;
            $display("FAIL vld_timeout actual=none required=vld within %0d clks", limit);
        end
    endtask

    task automatic wait_fill(input int fill, input bit need_odd);
        int n;
        for (n = 0; n < 2000 && !(m_win.size() >= fill && (!need_odd || m_edge % 2 == 1)); n++)
            @(negedge clk);
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL window_fill_timeout actual=%0d required=%0d", m_win.size(), fill);
        end
    endtask

    typedef struct {
        logic        lvl;
        int          nth;
        logic [15:0] req;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n, last, cyc, d, f, vcnt;
        logic [15:0] held;
        logic [15:0] loop_duty[3];

        tbl[0] = '{1'b1, 1, 16'h1FFF};
        tbl[1] = '{1'b1, 2, 16'h3FFF};
        tbl[2] = '{1'b1, 3, 16'h5FFF};
        tbl[3] = '{1'b1, 4, 16'h7FFF};
        tbl[4] = '{1'b1, 5, 16'h7FFF};
        tbl[5] = '{1'b0, 1, 16'hE000};
        tbl[6] = '{1'b0, 2, 16'hC000};
        tbl[7] = '{1'b0, 3, 16'hA000};
        tbl[8] = '{1'b0, 4, 16'h8000};
        tbl[9] = '{1'b0, 5, 16'h8000};

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_duty4", {16'h0, duty4}, 32'h0);
        check("reset_vld4", {31'h0, vld4}, 32'h0);

        // LOG2_WIN=4 constant-level table; synchronizer pre-filled with en low
        cyc = 0;
        last = 0;
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].nth == 1) begin
                do_reset();
                mode = 0;
                level = tbl[i].lvl;
                repeat (4) @(negedge clk);
                en = 1'b1;
                cyc = 0;
            end
            wait_vld(1'b0, 100, n);
            cyc += n;
            check($sformatf("l4_duty[%0d]", i), {16'h0, duty4}, {16'h0, tbl[i].req});
            if (tbl[i].nth > 1) check($sformatf("l4_period[%0d]", i), cyc - last, 32);
            last = cyc;
        end

        // Alternating samples give raw = W/2, i.e. zero duty
        do_reset();
        mode = 2;
        tgl = 0;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_vld(1'b1, 1200, n);
            check($sformatf("alt_duty[%0d]", k), {16'h0, duty8}, 32'h0);
        end

        // Loopback through a first-order sigma-delta modulator
        loop_duty[0] = 16'h4000;
        loop_duty[1] = 16'hC000;
        loop_duty[2] = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            do_reset();
            sd_duty = loop_duty[k];
            sd_acc = 16'h0000;
            mode = 3;
            en = 1'b1;
            repeat (4) wait_vld(1'b1, 1200, n);
            d = int'($signed(duty8)) - int'($signed(loop_duty[k]));
            if (d < 0) d = -d;
            check($sformatf("loop_err_le_100[%h]", loop_duty[k]), {31'h0, d <= 256}, 32'h1);
        end

        // Random stream with random en drops, covered by the model
        do_reset();
        mode = 1;
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(700, 300)) @(negedge clk);
            en = 1'b0;
            repeat ($urandom_range(20, 1)) @(negedge clk);
            en = 1'b1;
        end
        repeat (1500) @(negedge clk);

        // en low for 10 clks mid-window
        wait_vld(1'b1, 1200, n);
        wait_fill(100, 1'b0);
        held = duty8;
        en = 1'b0;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            vcnt += int'(vld8);
        end
        check("en_off_no_vld", vcnt, 0);
        check("en_off_duty_held", {16'h0, duty8}, {16'h0, held});
        en = 1'b1;
        f = (m_edge % 2 == 1) ? m_edge : m_edge + 1;
        wait_vld(1'b1, 1200, n);
        check("en_restart_span", m_edge - f, 512);

        // en falls on the dump edge: the window is lost
        wait_fill(255, 1'b1);
        en = 1'b0;
        vcnt = 0;
        repeat (6) begin
            @(negedge clk);
            vcnt += int'(vld8);
        end
        check("en_vs_dump_no_vld", vcnt, 0);
        en = 1'b1;

        // Asynchronous reset mid-window
        do_reset();
        mode = 0;
        level = 1'b1;
        en = 1'b1;
        repeat (5) wait_vld(1'b1, 1200, n);
        check("ones_steady8", {16'h0, duty8}, 32'h7FFF);
        wait_fill(100, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_duty8", {16'h0, duty8}, 32'h0);
        check("async_rst_vld8", {31'h0, vld8}, 32'h0);
        check("async_rst_duty4", {16'h0, duty4}, 32'h0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_vld(1'b1, 1200, n);
        check("rst_latency_ge_2w", {31'h0, n >= 512}, 32'h1);
        // first sample after reset is the cleared synchronizer, so raw = 255
        check("rst_first_duty8", {16'h0, duty8}, 32'h1FC0);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdm_demod.md
# pdm_demod

PDM-to-PCM demodulator: recovers a 16-bit signed duty word from a 1-bit pulse-density stream produced by the team's PDM modulator.
- Samples the stream on the same every-other-clock cadence as the modulator.
- Counts ones over a fixed window (integrate-and-dump), rescales the count to 16 bits and averages the last four windows.
- Sits at the receive/monitor end of a PDM link, or in loopback benches closing the modulator path.

## Interface
- LOG2_WIN, default 8: log2 of window length in samples; legal range 4..16. W = 2^LOG2_WIN.
- clk  in  1  system clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk.
- en  in  1  demodulation enable; low aborts and holds
- pdm_in  in  1  PDM bit stream, may be asynchronous to clk
- duty_out  out  16  signed two's-complement recovered duty; reset 16'h0000
- vld  out  1  one-clk pulse when duty_out updates; reset 0

## Operation
- pdm_in passes through a 2-flop synchronizer (reset 0) before use.
- smp strobe: flop, reset 0, toggles every clk regardless of en. Its phase matches the modulator's update flop when both leave reset on the same edge.
- Window counter (LOG2_WIN bits) and ones accumulator (LOG2_WIN+1 bits) advance only on edges with en && smp. On each such edge, ones += synchronized bit.
- Dump edge: en && smp && cnt == W-1.
  - raw = ones + current bit, range 0..W.
  - scaled = raw << (16-LOG2_WIN), computed 17 bits wide.
  - Saturate scaled to 16'hFFFF, then win_val = scaled - 16'h8000. This inverts the modulator's duty + 16'h8000 offset.
  - cnt and ones clear; win_rdy is set.
- Averaging stage, on the edge after a dump (win_rdy):
  - sum = win_val + hist0 + hist1 + hist2, 18-bit signed.
  - duty_out <= sum >>> 2 (arithmetic shift, truncates toward -inf).
  - hist2 <= hist1, hist1 <= hist0, hist0 <= win_val.
  - vld <= 1.
  - hist* reset to 16'h0000.
- vld deasserts on the following edge. duty_out holds between updates.
- en low on any edge: cnt, ones and win_rdy clear, so a partial window is discarded and produces no vld. hist*, duty_out and smp are retained.
- en rising: the first counted sample is the next en && smp edge.
- Reset mid-window: every register returns to its reset value immediately. The first vld after release comes no earlier than 2W clks later.
- en falling on the same edge as a dump: en wins; no dump and no vld.

## Timing
- pdm_in to accumulator: 2 clk synchronizer plus wait for the next smp edge.
- Sample rate is clk/2; window period is 2W clks.
- Dump edge E0 registers win_val. Edge E1 updates duty_out and raises vld. Edge E2 drops vld.
- vld period is exactly 2W clks while en stays high.
- Step response settles to the final value on the 4th vld after the step window.

## Structure
- Package pdm_pkg holds:
  - localparam MID = 16'h8000
  - typedef logic signed [15:0] pdm_duty_t
  - function sat16 (17-bit unsigned to 16-bit clamp), shared with the modulator.
- One sub-module: pdm_window_integ. It contains the synchronizer, smp strobe, window counter, accumulator and scaling, and emits win_val/win_rdy.
- Top-level pdm_demod contains the history registers, averaging adder and vld.

## Test plan
- LOG2_WIN=4, pdm_in held 1, en=1:
  - window values are 16'h7FFF (saturated);
  - successive duty_out values are 16'h1FFF, 16'h3FFF, 16'h5FFF, 16'h7FFF, then steady 16'h7FFF;
  - vld every 32 clks.
- LOG2_WIN=4, pdm_in held 0: duty_out steps 16'hE000, 16'hC000, 16'hA000, 16'h8000, then steady.
- LOG2_WIN=8, pdm_in toggling on every smp edge (alternating 1/0 samples): every window raw=128 → win_val 16'h0000 → duty_out 16'h0000.
- Loopback with the modulator (same clk/reset), LOG2_WIN=8, duty=16'h4000: after 4 vld pulses, duty_out is within ±16'h0100 of 16'h4000. Repeat with 16'hC000 and 16'h0000.
- en deasserted for 10 clks mid-window: no vld for that window; duty_out unchanged; next vld exactly 2W clks after the first en && smp edge following re-assert (counted from that edge through E1).
- rst_n pulsed low mid-window: duty_out=16'h0000 and vld=0 immediately (asynchronous); hist cleared, so first post-reset output reflects a single window divided by 4.
